instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Driver end of the control unit's instruction input. It owns the PC, requests instruction words from the instruction memory/icache, and presents a stable `instr` word to the control unit.
- It takes back the decoded `PCSrc`, `imm16`, `j_addr26` and `halt`, computes the next PC, and sequences fetch/execute on a multicycle datapath.
- It sits between the icache port and control_unit.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- ihit  input  1  icache hit; imemload valid this cycle
- imemload  input  32  instruction word from icache
- imemREN  output  1  instruction read request
- imemaddr  output  32  instruction address (= pc)
- instr  output  32  latched instruction, drives control unit instr
- instr_valid  output  1  high while instr is being executed (EXEC state)
- PCSrc  input  PCSrc_t  next-PC select from control unit (PC4, BR, J, JR)
- imm16  input  16  branch offset from control unit
- j_addr26  input  26  jump target field from control unit
- br_taken  input  1  branch condition result (zero flag qualified by zero_sel, computed in datapath)
- rdat1  input  32  register value for JR
- exec_stall  input  1  datapath not done with current instr (e.g. dmem wait)
- halt  input  1  halt decoded by control unit
- pc  output  32  current PC
- pc_plus4  output  32  pc + 4, for JAL write-back
- halted  output  1  sticky halt indication

Behaviour:
- Reset (RST high at a rising edge) gives:
  - state = FETCH, pc = PC_RESET, instr = 32'h0, instr_valid = 0, halted = 0.
  - imemREN = 1 in the first cycle after reset.
- Reset mid-operation aborts any fetch or exec immediately. No PC update occurs that cycle.
- States (fetch_state_t): FETCH, EXEC, HALTED.
- FETCH:
  - imemREN = 1, imemaddr = pc.
  - ihit = 0: hold.
  - ihit = 1: instr <= imemload and go to EXEC next cycle. Latency from entry to EXEC is 1 cycle when ihit is immediate.
- EXEC:
  - imemREN = 0, instr_valid = 1. instr is stable the whole state.
  - halt = 1 (has priority over exec_stall): go to HALTED with pc unchanged.
  - exec_stall = 1: hold state and pc.
  - Otherwise: pc <= next_pc and go to FETCH.
- HALTED:
  - imemREN = 0, instr_valid = 0, halted = 1.
  - Stays here until RST; all inputs are ignored.
- next_pc, all arithmetic mod 2^32:
  - PC4: pc + 4.
  - BR: pc + 4 + (sign_ext(imm16) << 2) if br_taken, else pc + 4.
  - J: {pc_plus4[31:28], j_addr26, 2'b00}.
  - JR: {rdat1[31:2], 2'b00}; low bits are forced to zero.
- Boundary cases:
  - pc = 32'hFFFF_FFFC with PC4 wraps to 0.
  - A negative imm16 branching below 0 wraps.
- ihit outside FETCH is ignored. imemload is sampled only on FETCH & ihit.
- Outputs are registered, except imemREN, instr_valid, pc_plus4 and halted, which are decoded from state and pc.

Decomposition:
- Add fetch_state_t (FETCH, EXEC, HALTED) to diaosi_types_pkg. Reuse PCSrc_t and word_t from the existing packages.
- One combinational sub-module, next_pc_calc (pc, PCSrc, imm16, j_addr26, br_taken, rdat1 -> next_pc, pc_plus4), is natural.

Test Plan:
- Reset, then ihit=1 with imemload=32'h2001_0005 -> imemaddr=0, instr=32'h2001_0005 and instr_valid=1 next cycle; PC4 -> pc=4 and back in FETCH.
- ihit held 0 for 3 cycles at pc=8 -> imemREN=1 and imemaddr=8 throughout; instr is unchanged until ihit.
- Branches at pc=32'h10:
  - BR, imm16=16'hFFFC, br_taken=1 -> pc=32'h4.
  - Same with br_taken=0 -> pc=32'h14.
- J at pc=32'h1000_0000 with j_addr26=26'h40 -> pc=32'h1000_0100. JR with rdat1=32'h123 -> pc=32'h120.
- EXEC with exec_stall=1 for 2 cycles, then halt=1 alongside stall -> pc held; HALTED with halted=1 and imemREN=0; further ihit is ignored.
- RST asserted during EXEC at pc=32'h40 -> next cycle pc=PC_RESET, state FETCH, instr_valid=0, halted=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: machine word, next-PC select
// and the fetch/execute sequencing states.
package instr_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC4 = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } PCSrc_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, absolute
// jump within the current 256 MB region, and register-indirect jump.
module instr_fetch_unit_next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  word_t       pc,
    input  PCSrc_t      PCSrc,
    input  logic [15:0] imm16,
    input  logic [25:0] j_addr26,
    input  logic        br_taken,
    input  word_t       rdat1,
    output word_t       next_pc,
    output word_t       pc_plus4
);

    logic signed [31:0] br_offset;
    word_t              br_target;
    word_t              j_target;
    word_t              jr_target;

    assign pc_plus4  = pc + PC_STEP;
    // Word offset: sign-extend then scale by 4; wraps naturally mod 2^32.
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target = pc_plus4 + word_t'(br_offset);
    assign j_target  = {pc_plus4[31:28], j_addr26, 2'b00};
    assign jr_target = rdat1 & ~word_t'(32'h3);

    always_comb begin
        next_pc = pc_plus4;
        unique case (PCSrc)
            PC4: next_pc = pc_plus4;
            BR:  next_pc = br_taken ? br_target : pc_plus4;
            J:   next_pc = j_target;
            JR:  next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from the icache, holds the
// instruction steady for the control unit and sequences fetch/execute/halt.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       imemload,
    output logic        imemREN,
    output word_t       imemaddr,
    output word_t       instr,
    output logic        instr_valid,
    input  PCSrc_t      PCSrc,
    input  logic [15:0] imm16,
    input  logic [25:0] j_addr26,
    input  logic        br_taken,
    input  word_t       rdat1,
    input  logic        exec_stall,
    input  logic        halt,
    output word_t       pc,
    output word_t       pc_plus4,
    output logic        halted
);

    fetch_state_t state, state_next;
    word_t        pc_r, pc_next;
    word_t        instr_r, instr_next;
    word_t        calc_pc;

    instr_fetch_unit_next_pc_calc u_next_pc (
        .pc       (pc_r),
        .PCSrc    (PCSrc),
        .imm16    (imm16),
        .j_addr26 (j_addr26),
        .br_taken (br_taken),
        .rdat1    (rdat1),
        .next_pc  (calc_pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc_r    <= PC_RESET;
            instr_r <= '0;
        end else begin
            state   <= state_next;
            pc_r    <= pc_next;
            instr_r <= instr_next;
        end
    end

    // Halt outranks stall so a halting instruction never lingers in EXEC.
    always_comb begin
        state_next = state;
        pc_next    = pc_r;
        instr_next = instr_r;
        unique case (state)
            FETCH: begin
                if (ihit) begin
                    instr_next = imemload;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (!exec_stall) begin
                    pc_next    = calc_pc;
                    state_next = FETCH;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    assign pc          = pc_r;
    assign imemaddr    = pc_r;
    assign instr       = instr_r;
    assign imemREN     = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);

endmodule
